riscv_mem_responder: RTL
========================

// Module: riscv_mem_responder
// PURPOSE
//  Memory-side responder for riscv_core's instruction and data ports: a unified
//  word RAM with asynchronous read and synchronous write. It serves instruction
//  fetch and load/store traffic, and holds the core in reset while a program
//  image is streamed in over a valid/ready loader port. It also reports
//  misaligned and out-of-range accesses. Sits between riscv_core and the
//  testbench/boot source.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; MEM_WORDS = 2**ADDR_WIDTH, byte range 0..4*MEM_WORDS-1
//  BOOT_LOAD   1   1: leave reset in LOAD state; 0: leave reset in RUN state
//  NOP_WORD    32'h00000013  fetch value returned for out-of-range addresses or while in LOAD
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst_n        in   1   asynchronous active-low reset
//  instr_addr   in   32  core fetch byte address
//  instr_data   out  32  fetched word (combinational)
//  data_addr    in   32  core load/store byte address
//  data_wdata   in   32  store data
//  data_rdata   out  32  load data (combinational)
//  data_we      in   1   store request
//  data_re      in   1   load request
//  load_start   in   1   pulse: (re)enter LOAD, pointer to 0
//  load_valid   in   1   loader word valid
//  load_data    in   32  loader word
//  load_last    in   1   qualifies final loader word
//  load_ready   out  1   high in LOAD state
//  core_rst_n   out  1   registered; low in LOAD, high in RUN
//  fault_misaligned out 1  sticky: unaligned core access seen
//  fault_range  out  1   sticky: out-of-range core access seen
//  fault_count  out  8   saturating count of faulting cycles
// BEHAVIOUR
//  - Word index = addr[ADDR_WIDTH+1:2]. In range iff addr < 4*MEM_WORDS. RAM is not cleared by reset.
//  - Reset: state=LOAD if BOOT_LOAD else RUN; ptr=0; core_rst_n=0; faults=0; fault_count=0.
//    core_rst_n rises on the first edge in RUN (one-cycle latency after entering RUN).
//  - FSM LOAD: load_ready=1. Each edge with load_valid writes mem[ptr]=load_data and increments ptr.
//    LOAD->RUN on a handshake with load_last=1, or on a handshake at ptr=MEM_WORDS-1 (no wrap).
//    load_start in LOAD: ptr:=0, remain in LOAD; load_start takes priority over a same-cycle handshake.
//  - FSM RUN: load_ready=0; load_valid is ignored. load_start: ->LOAD, ptr:=0, core_rst_n:=0 next edge,
//    faults and count cleared.
//  - instr_data: mem[idx] in RUN and in range; NOP_WORD otherwise.
//  - data_rdata: mem[idx] if data_re and in range and aligned; else 32'h0.
//  - Store: in RUN, on posedge when data_we is high and the address is aligned and in range.
//    Faulting stores are dropped. All core stores are dropped in LOAD.
//  - Same-cycle read/write to one address (data or fetch): the read returns the old word; the new word
//    is visible from the next cycle.
//  - Faults (RUN only): misaligned if (data_we|data_re)&&data_addr[1:0]!=0, or instr_addr[1:0]!=0.
//    Range fault if data or fetch address is out of range. fault_count += 1 per cycle with any fault,
//    saturating at 255.
//  - Async reset mid-load aborts the load; ptr returns to 0 and RAM keeps the partial image.
// TESTING
//  1 reset, BOOT_LOAD=1; stream 00500093, 00308113, 002081b3 with last on 3rd -> core_rst_n=1 one
//    cycle after last handshake; instr_data@0/4/8 = those words; instr_data@12 = mem content.
//  2 RUN: we=1 addr=0x100 wdata=DEADBEEF, re=1 same cycle -> rdata=old; next cycle re -> DEADBEEF.
//  3 re=1 addr=0x102 -> rdata=0, fault_misaligned=1, fault_count=1; store to 0x102 leaves mem[0x40] unchanged.
//  4 ADDR_WIDTH=10: fetch addr 0x1000 -> instr_data=00000013, fault_range=1; re 0x1000 -> rdata=0.
//  5 load_start in RUN with faults set -> core_rst_n=0 next edge, faults/count=0, reload 1 word at 0 -> RUN.
//  6 stream 1024 words without last -> RUN after 1024th handshake; rst_n pulse mid-load -> LOAD, ptr=0.

Source files
------------

// File: rtl/riscv_mem_responder.sv
// Unified word RAM for riscv_core fetch and load/store ports, with a valid/ready boot
// loader that holds the core in reset while a program image is streamed in.
module riscv_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          BOOT_LOAD  = 1'b1,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic        data_re,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_rst_n,
  output logic        fault_misaligned,
  output logic        fault_range,
  output logic [7:0]  fault_count
);

  localparam int unsigned MEM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  fault_mis_q, fault_mis_d;
  logic                  fault_rng_q, fault_rng_d;
  logic [7:0]            fault_cnt_q, fault_cnt_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  logic [ADDR_WIDTH-1:0] instr_idx, data_idx;
  logic                  instr_in_range, data_in_range;
  logic                  instr_aligned, data_aligned;
  logic                  data_access;
  logic                  in_run;
  logic                  mis_now, rng_now;

  // In range iff every bit above the byte range is zero.
  assign instr_idx      = instr_addr[ADDR_WIDTH+1:2];
  assign data_idx       = data_addr[ADDR_WIDTH+1:2];
  assign instr_in_range = (instr_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign data_in_range  = (data_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign instr_aligned  = instr_addr[1:0] == 2'b00;
  assign data_aligned   = data_addr[1:0] == 2'b00;
  assign data_access    = data_we | data_re;
  assign in_run         = state_q == ST_RUN;

  assign mis_now = in_run & ((data_access & ~data_aligned) | ~instr_aligned);
  assign rng_now = in_run & ((data_access & ~data_in_range) | ~instr_in_range);

  // Asynchronous reads: a same-cycle write lands at the edge, so reads see the old word.
  assign instr_data = (in_run && instr_in_range) ? mem_q[instr_idx] : NOP_WORD;
  assign data_rdata = (data_re && data_in_range && data_aligned) ? mem_q[data_idx] : 32'h0;

  assign load_ready       = ~in_run;
  assign core_rst_n       = core_rst_n_q;
  assign fault_misaligned = fault_mis_q;
  assign fault_range      = fault_rng_q;
  assign fault_count      = fault_cnt_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    core_rst_n_d = 1'b0;
    fault_mis_d  = fault_mis_q | mis_now;
    fault_rng_d  = fault_rng_q | rng_now;
    fault_cnt_d  = fault_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = load_data;

    if ((mis_now || rng_now) && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end

    unique case (state_q)
      ST_LOAD: begin
        // A restart request wins over a word offered in the same cycle.
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid) begin
          mem_we = 1'b1;
          if (load_last || (ptr_q == PTR_MAX)) begin
            state_d = ST_RUN;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      ST_RUN: begin
        core_rst_n_d = 1'b1;
        if (load_start) begin
          state_d      = ST_LOAD;
          ptr_d        = '0;
          core_rst_n_d = 1'b0;
          fault_mis_d  = 1'b0;
          fault_rng_d  = 1'b0;
          fault_cnt_d  = 8'd0;
        end else if (data_we && data_aligned && data_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = data_idx;
          mem_wdata = data_wdata;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // RAM contents survive reset so a partial image is kept across an aborted load.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      ptr_q        <= '0;
      core_rst_n_q <= 1'b0;
      fault_mis_q  <= 1'b0;
      fault_rng_q  <= 1'b0;
      fault_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      core_rst_n_q <= core_rst_n_d;
      fault_mis_q  <= fault_mis_d;
      fault_rng_q  <= fault_rng_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

endmodule
